// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter around a single registered-output ALU.
// One operation in flight; result, zero, overflow and illegal flags are
// captured into a held response register until the owner consumes it.

module ALU #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } alu_op_e;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;

  // Combinational datapath; overflow is the carry/borrow out for ADD/SUB.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (ctrl)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result   = sum[WIDTH-1:0];
        overflow = sum[WIDTH];
      end
      OP_SUB: begin
        result   = diff[WIDTH-1:0];
        overflow = diff[WIDTH];
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: result = ~(a | b);
      default: illegal = 1'b1;
    endcase
  end

  // Registered result: valid one cycle after the operands are presented.
  always_ff @(posedge clk) begin
    out <= result;
  end

  assign zero = (out == '0);

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [7:0]         req_ctrl,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_out,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_illegal,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic             owner;
  logic             last_grant;
  logic [1:0]       grant;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_illegal;

  ALU #(.WIDTH(WIDTH)) u_alu (
    .clk      (clk),
    .ctrl     (ctrl_q),
    .a        (a_q),
    .b        (b_q),
    .out      (alu_out),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .illegal  (alu_illegal)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Ready is masked during reset so nothing looks accepted on a reset edge.
  assign req_ready = (state == IDLE && rst_n) ? grant : '0;
  assign rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : '0;
  assign busy      = (state != IDLE);

  // Request/issue/capture/response sequencer with held response fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      rsp_out      <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            owner      <= req_ready[1];
            last_grant <= req_ready[1];
            a_q        <= req_ready[1] ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
            b_q        <= req_ready[1] ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
            ctrl_q     <= req_ready[1] ? req_ctrl[7:4] : req_ctrl[3:0];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_overflow <= alu_overflow;
          rsp_illegal  <= alu_illegal;
          state        <= CAPTURE;
        end
        CAPTURE: begin
          rsp_out  <= alu_out;
          rsp_zero <= alu_zero;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: cycle model of the handshake FSM plus a scoreboard
// of expected results pushed on acceptance and checked while held.

module tb_alu_arbiter;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [7:0]     req_ctrl;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_out;
  logic           rsp_zero;
  logic           rsp_overflow;
  logic           rsp_illegal;
  logic           busy;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ctrl     (req_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_out      (rsp_out),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0] out;
    logic         zero;
    logic         ov;
    logic         ill;
    logic         chk_ov;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.out = '0; e.ov = 1'b0; e.ill = 1'b0; e.chk_ov = 1'b1;
    s = {1'b0, a} + {1'b0, b};
    case (c)
      C_AND: e.out = a & b;
      C_OR:  e.out = a | b;
      C_ADD: begin e.out = s[W-1:0]; e.ov = s[W]; end
      C_SUB: begin e.out = a - b; e.chk_ov = 1'b0; end
      C_SLT: e.out = ($signed(a) < $signed(b)) ? 1 : 0;
      C_NOR: e.out = ~(a | b);
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.out == '0);
    return e;
  endfunction

  // Cycle model of the arbiter, sampled on the falling edge.
  int unsigned mphase  = 0;
  logic        mlast   = 1'b1;
  logic        mowner  = 1'b0;
  logic        started = 1'b0;

  always @(negedge clk) begin
    logic [1:0] eg;
    logic [1:0] erv;
    eg = '0;
    if (mphase == 0 && rst_n) begin
      case (req_valid)
        2'b01: eg = 2'b01;
        2'b10: eg = 2'b10;
        2'b11: eg = mlast ? 2'b01 : 2'b10;
        default: eg = '0;
      endcase
    end
    erv = (mphase == 3) ? (mowner ? 2'b10 : 2'b01) : 2'b00;
    if (started) begin
      check("req_ready", {62'd0, req_ready}, {62'd0, eg});
      check("rsp_valid", {62'd0, rsp_valid}, {62'd0, erv});
      check("busy", {63'd0, busy}, {63'd0, (mphase != 0)});
      if (mphase == 3) begin
        if (q.size() == 0) check("rsp_without_op", 64'd1, 64'd0);
        else begin
          check("rsp_out", {32'd0, rsp_out}, {32'd0, q[0].out});
          check("rsp_zero", {63'd0, rsp_zero}, {63'd0, q[0].zero});
          check("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, q[0].ill});
          if (q[0].chk_ov) check("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, q[0].ov});
        end
      end
    end
    if (!rst_n) begin
      started = 1'b1;
      mphase  = 0;
      mlast   = 1'b1;
      q.delete();
    end else if (started) begin
      case (mphase)
        0: if (eg != 2'b00) begin
          mowner = eg[1];
          mlast  = eg[1];
          q.push_back(model(req_ctrl[mowner*4 +: 4], req_a[mowner*W +: W], req_b[mowner*W +: W]));
          mphase = 1;
        end
        1: mphase = 2;
        2: mphase = 3;
        default: if (rsp_ready[mowner]) begin
          void'(q.pop_front());
          mphase = 0;
        end
      endcase
    end
  end

  task automatic set_req(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_ctrl[i*4 +: 4] = c;
    req_valid[i]     = 1'b1;
  endtask

  // Present one request and drop it right after the acceptance edge.
  task automatic issue(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    bit got = 0;
    set_req(i, a, b, c);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin got = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (!got) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    @(posedge clk); #1;
    if (!got) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
    check({tag, "_rsp_out"}, {32'd0, rsp_out}, 64'd0);
    check({tag, "_rsp_zero"}, {63'd0, rsp_zero}, 64'd0);
    check({tag, "_rsp_ov"}, {63'd0, rsp_overflow}, 64'd0);
    check({tag, "_rsp_ill"}, {63'd0, rsp_illegal}, 64'd0);
  endtask

  // Run a tie with both requesters held valid and record the grant order.
  task automatic tie_run(input int unsigned n, output logic [3:0] order);
    int unsigned cnt = 0;
    order = '0;
    for (int k = 0; k < 80 && cnt < n; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        order[cnt] = req_ready[1];
        cnt++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    if (cnt != n) check("tie_timeout", 64'(cnt), 64'(n));
  endtask

  initial begin
    logic [3:0] order;
    bit got;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_req_ready", {62'd0, req_ready}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 32'd5, 32'd7, C_ADD);                 wait_idle();
    issue(1, 32'hFFFF_FFFF, 32'd1, C_ADD);         wait_idle();
    issue(1, 32'd3, 32'd3, C_SUB);                 wait_idle();
    issue(0, 32'h1234, 32'h5678, 4'b1010);         wait_idle();
    issue(1, 32'hFFFF_FFFE, 32'd1, C_SLT);         wait_idle();
    issue(0, 32'd1, 32'hFFFF_FFFE, C_SLT);         wait_idle();
    issue(1, 32'hF0F0_0000, 32'h0000_0F0F, C_NOR); wait_idle();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] ops [6];
      ops = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_NOR};
      issue(k % 2, $urandom, $urandom, ops[k]);
      wait_idle();
    end

    // Backpressure: response held for 5 cycles while requester 1 waits.
    rsp_ready = 2'b00;
    issue(0, 32'hA5, 32'h5A, C_OR);
    set_req(1, 32'd10, 32'd4, C_SUB);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin got = 1; break; end
    end
    if (!got) check("rsp_timeout", 64'd0, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 2'b01;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin got = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    if (!got) check("bp_accept_timeout", 64'd0, 64'd1);
    rsp_ready = 2'b11;
    wait_idle();

    // Tie fairness from reset.
    rst_n = 1'b0;
    set_req(0, 32'hF0, 32'h3C, C_AND);
    set_req(1, 32'hF0, 32'h3C, C_OR);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tie_run(4, order);
    check("tie_order", {60'd0, order}, 64'b1010);
    wait_idle();

    // Reset asserted while the operation is in CAPTURE.
    issue(0, 32'd9, 32'd4, C_ADD);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_outputs("midop");
    repeat (4) @(posedge clk);
    #1;
    check("midop_no_rsp", {62'd0, rsp_valid}, 64'd0);
    set_req(0, 32'd2, 32'd2, C_ADD);
    set_req(1, 32'd6, 32'd1, C_SUB);
    tie_run(2, order);
    check("post_reset_tie", {62'd0, order[1:0]}, 64'b10);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `ALU` instance (WIDTH-bit, registered output on `clk`) between two requesters, e.g. the EX-stage issue path and the branch/address-compare path.
- Per-requester valid/ready request handshake; per-requester valid/ready response handshake.
- Round-robin grant; one operation in flight at a time.
- Sequences the ALU's one-cycle registered latency and captures `out`, `zero` and `overflow` into a held response register.

Parameters:
- WIDTH, 32, operand/result width; passed through to the internal `ALU`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: arbiter accepts requester i this cycle.
- req_a  input  2*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  operand b; same packing as req_a.
- req_ctrl  input  8  ALU control code; requester i at [i*4 +: 4].
- rsp_valid  output  2  bit i: response for requester i is held.
- rsp_ready  input  2  bit i: requester i consumes the response.
- rsp_out  output  WIDTH  result; shared bus, qualified by rsp_valid.
- rsp_zero  output  1  result equals 0.
- rsp_overflow  output  1  ALU overflow/carry-out for ADD/SUB; 0 otherwise.
- rsp_illegal  output  1  ctrl code was not AND/OR/ADD/SUB/SLT/NOR.
- busy  output  1  state != IDLE.

Behaviour:
- FSM states, all transitions on rising edge of `clk`:
  - IDLE: req_ready = grant one-hot; on req_valid[g] & req_ready[g], latch a, b, ctrl and owner = g; go ISSUE.
  - ISSUE: operand registers drive the ALU. Latch overflow (combinational from ctrl/a/b) and the illegal flag at end of cycle; ALU registers out at this edge. Go CAPTURE.
  - CAPTURE: ALU out and zero are valid; load rsp_out and rsp_zero. Go RESP.
  - RESP: rsp_valid[owner] = 1 and all response fields held stable. On rsp_ready[owner], go IDLE; otherwise stay.
- Operand and ctrl registers hold their values from ISSUE through CAPTURE. The ALU must see stable inputs for both of those cycles.
- Latency:
  - Acceptance edge at t gives rsp_valid high from the cycle after edge t+2.
  - Minimum issue interval is 4 cycles; the next accept is in the IDLE cycle after the response handshake.
- req_ready is nonzero only in IDLE and is at most one-hot. It may be high only for a requester whose req_valid is high.
- Grant rule:
  - Only one valid requester: grant it.
  - Both valid: grant the requester != last_grant.
  - last_grant updates on every accept.
- Codebase control encoding:
  - AND = 4'b0000
  - OR = 4'b0001
  - ADD = 4'b0010
  - SUB = 4'b0110
  - SLT = 4'b0111
  - NOR = 4'b1100
- Any other code is still issued. The ALU yields 0, so rsp_out = 0, rsp_zero = 1, rsp_overflow = 0, rsp_illegal = 1.
- rsp_valid bit for the non-owner is always 0. rsp_ready bits for the non-owner, or outside RESP, are ignored.
- Dropping req_valid before acceptance has no effect. Operands are sampled only on the acceptance edge.
- Reset (rst_n = 0 at any edge, including mid-operation):
  - State goes to IDLE and any in-flight operation is discarded.
  - last_grant = 1, so requester 0 wins the first tie.
  - req_ready = 0, rsp_valid = 0, rsp_out = 0, rsp_zero = 0, rsp_overflow = 0, rsp_illegal = 0, busy = 0.
  - Operand registers are cleared to 0.

Test Plan:
- Single ADD: req0 with a = 5, b = 7, ctrl = 0010. Expect acceptance, then rsp_valid = 2'b01 two cycles later with rsp_out = 12, zero = 0, overflow = 0. Handshake returns to IDLE.
- Zero/overflow: req1 ADD with a = 32'hFFFFFFFF, b = 1. Expect rsp_out = 0, rsp_zero = 1, rsp_overflow = 1. Then req1 SUB with a = 3, b = 3 gives rsp_out = 0, rsp_zero = 1.
- Tie fairness: both req_valid held high from reset with ops AND (0xF0 & 0x3C) and OR. Expect grant order req0, req1, req0, req1. Responses are 0x30, then 0xFC.
- Backpressure: hold rsp_ready = 0 for 5 cycles during RESP. rsp_valid and rsp_out stay stable, req_ready = 0 and busy = 1 throughout. Release, and the next request is accepted in the following IDLE cycle.
- Illegal/SLT: ctrl = 4'b1010 gives rsp_out = 0, rsp_illegal = 1. SLT with a = 32'hFFFFFFFE (-2), b = 1 gives rsp_out = 1.
- Reset mid-op: assert rst_n = 0 during CAPTURE. The next cycle shows IDLE, all outputs 0, and no rsp_valid for the dropped op. The first subsequent tie grants req0.
